// File: rtl/pci_la_trigger.sv
// PCI logic-analyser trigger: mask/value comparator, pre/post-trigger
// capture sequencer and write-side driver for the acquisition RAM.
module pci_la_trigger #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned WIDTH      = 48
) (
    input  logic                  PCI_CLK,
    input  logic                  PCI_RSTn,
    input  logic [WIDTH-1:0]      sample_in,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_addr,
    input  logic [31:0]           cfg_wdata,
    output logic [31:0]           cfg_rdata,
    output logic                  ram_we,
    output logic [DEPTH_LOG2-1:0] ram_addr,
    output logic [WIDTH-1:0]      ram_wdata,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Fill count at which the acquisition RAM holds a full buffer.
    localparam logic [DEPTH_LOG2:0] FILL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    state_t                state_q,    state_d;
    logic [31:0]           mask_lo_q,  mask_lo_d;
    logic [15:0]           mask_hi_q,  mask_hi_d;
    logic [31:0]           value_lo_q, value_lo_d;
    logic [15:0]           value_hi_q, value_hi_d;
    logic [1:0]            ctrl_q,     ctrl_d;
    logic [DEPTH_LOG2-1:0] post_q,     post_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q,   wr_ptr_d;
    logic [DEPTH_LOG2-1:0] trig_q,     trig_d;
    logic [DEPTH_LOG2-1:0] post_cnt_q, post_cnt_d;
    logic [DEPTH_LOG2:0]   fill_q,     fill_d;
    logic [WIDTH-1:0]      s_q,        s_d;
    logic                  m_q,        m_d;

    logic [WIDTH-1:0]      mask_w;
    logic [WIDTH-1:0]      value_w;
    logic [DEPTH_LOG2:0]   thresh;
    logic                  match;
    logic                  hit;
    logic                  qual;
    logic                  ctrl_wr;

    assign mask_w  = WIDTH'({mask_hi_q, mask_lo_q});
    assign value_w = WIDTH'({value_hi_q, value_lo_q});
    assign match   = ((s_q ^ value_w) & mask_w) == '0;
    assign hit     = ctrl_q[1] ? (match & ~m_q) : match;
    assign thresh  = FILL_FULL - {1'b0, post_q};
    assign qual    = fill_q >= thresh;
    assign ctrl_wr = cfg_we && (cfg_addr == 3'd4);

    assign ram_addr  = wr_ptr_q;
    assign ram_wdata = s_q;
    assign done      = (state_q == S_DONE);

    // Configuration/status read mux; unused bits read as zero.
    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            3'd0: cfg_rdata = mask_lo_q;
            3'd1: cfg_rdata[15:0] = mask_hi_q;
            3'd2: cfg_rdata = value_lo_q;
            3'd3: cfg_rdata[15:0] = value_hi_q;
            3'd4: cfg_rdata[1:0] = ctrl_q;
            3'd5: cfg_rdata[DEPTH_LOG2-1:0] = post_q;
            3'd6: begin
                cfg_rdata[1:0] = state_q;
                cfg_rdata[8 +: DEPTH_LOG2] = trig_q;
            end
            default: cfg_rdata = '0;
        endcase
    end

    // Next-state logic: register writes, capture sequencing and RAM write enable.
    always_comb begin
        state_d    = state_q;
        mask_lo_d  = mask_lo_q;
        mask_hi_d  = mask_hi_q;
        value_lo_d = value_lo_q;
        value_hi_d = value_hi_q;
        ctrl_d     = ctrl_q;
        post_d     = post_q;
        wr_ptr_d   = wr_ptr_q;
        trig_d     = trig_q;
        post_cnt_d = post_cnt_q;
        fill_d     = fill_q;
        s_d        = sample_in;
        m_d        = m_q;
        ram_we     = 1'b0;

        if (cfg_we) begin
            case (cfg_addr)
                3'd0: mask_lo_d  = cfg_wdata;
                3'd1: mask_hi_d  = cfg_wdata[15:0];
                3'd2: value_lo_d = cfg_wdata;
                3'd3: value_hi_d = cfg_wdata[15:0];
                3'd4: ctrl_d     = cfg_wdata[1:0];
                3'd5: post_d     = cfg_wdata[DEPTH_LOG2-1:0];
                default: ;
            endcase
        end

        case (state_q)
            S_ARMED: begin
                ram_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (fill_q != FILL_FULL) begin
                    fill_d = fill_q + 1'b1;
                end
                // Edge history only advances once hits can qualify, so a
                // level already present when the buffer fills counts as an edge.
                if (qual) begin
                    m_d = match;
                end
                if (qual && hit && !cfg_we) begin
                    trig_d     = wr_ptr_q;
                    post_cnt_d = post_q;
                    state_d    = S_POST;
                end
            end
            S_POST: begin
                if (post_cnt_q != '0) begin
                    ram_we     = 1'b1;
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    post_cnt_d = post_cnt_q - 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: ;
        endcase

        // A CTRL write overrides whatever the sequencer decided this cycle.
        if (ctrl_wr) begin
            if (cfg_wdata[0]) begin
                state_d    = S_ARMED;
                wr_ptr_d   = '0;
                fill_d     = '0;
                post_cnt_d = '0;
                m_d        = 1'b0;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // State and register update with asynchronous active-low reset.
    always_ff @(posedge PCI_CLK or negedge PCI_RSTn) begin
        if (!PCI_RSTn) begin
            state_q    <= S_IDLE;
            mask_lo_q  <= '0;
            mask_hi_q  <= '0;
            value_lo_q <= '0;
            value_hi_q <= '0;
            ctrl_q     <= '0;
            post_q     <= '0;
            wr_ptr_q   <= '0;
            trig_q     <= '0;
            post_cnt_q <= '0;
            fill_q     <= '0;
            s_q        <= '0;
            m_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_lo_q  <= mask_lo_d;
            mask_hi_q  <= mask_hi_d;
            value_lo_q <= value_lo_d;
            value_hi_q <= value_hi_d;
            ctrl_q     <= ctrl_d;
            post_q     <= post_d;
            wr_ptr_q   <= wr_ptr_d;
            trig_q     <= trig_d;
            post_cnt_q <= post_cnt_d;
            fill_q     <= fill_d;
            s_q        <= s_d;
            m_q        <= m_d;
        end
    end

endmodule

// File: tb/tb_pci_la_trigger.sv
// Directed self-checking bench for pci_la_trigger.
module tb_pci_la_trigger;

    localparam int DL = 8;
    localparam int W  = 48;
    // Matches VALUE_LO=0x200 under MASK_LO=all-ones, MASK_HI=0.
    localparam logic [W-1:0] HIT = 48'h0000_0000_0200;

    logic          PCI_CLK  = 1'b0;
    logic          PCI_RSTn = 1'b0;
    logic [W-1:0]  sample_in = '0;
    logic          cfg_we    = 1'b0;
    logic [2:0]    cfg_addr  = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic          ram_we;
    logic [DL-1:0] ram_addr;
    logic [W-1:0]  ram_wdata;
    logic          done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pci_la_trigger #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
        .PCI_CLK   (PCI_CLK),
        .PCI_RSTn  (PCI_RSTn),
        .sample_in (sample_in),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .done      (done)
    );

    always #5 PCI_CLK = ~PCI_CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge PCI_CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    // After this, cycle 0 is the first ARMED cycle (writes address 0).
    task automatic arm(input logic edge_m);
        cfg_write(3'd4, {30'd0, edge_m, 1'b1});
        cyc = 0;
    endtask

    task automatic advance_to(input int k);
        while (cyc < k) begin
            step();
            cyc++;
        end
    endtask

    // Makes sample k equal v; returns in the cycle that writes sample k.
    task automatic put_sample(input int k, input logic [W-1:0] v);
        advance_to(k - 1);
        sample_in = v;
        advance_to(k);
        sample_in = '0;
    endtask

    // Counts RAM writes from the current cycle until done rises.
    task automatic wait_done(output int writes, output bit timed_out);
        writes    = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (ram_we) writes++;
            step();
        end
    endtask

    task automatic set_ad_match(input logic [31:0] post);
        cfg_write(3'd0, 32'hFFFF_FFFF);
        cfg_write(3'd1, 32'h0);
        cfg_write(3'd2, 32'h0000_0200);
        cfg_write(3'd3, 32'h0);
        cfg_write(3'd5, post);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        PCI_RSTn  = 1'b0;
        sample_in = 48'hFFFF_FFFF_FFFF;
        repeat (2) @(posedge PCI_CLK);
        #1;
        if (ram_we !== 1'b0) begin $display("FAIL rst_ram_we got=%0b exp=0", ram_we); bad++; end
        total++;
        if (ram_addr !== 8'd0) begin $display("FAIL rst_ram_addr got=%0d exp=0", ram_addr); bad++; end
        total++;
        if (ram_wdata !== 48'd0) begin $display("FAIL rst_ram_wdata got=%0h exp=0", ram_wdata); bad++; end
        total++;
        if (done !== 1'b0) begin $display("FAIL rst_done got=%0b exp=0", done); bad++; end
        total++;
        for (int a = 0; a < 8; a++) begin
            cfg_read(3'(a), rd);
            if (rd !== 32'd0) begin $display("FAIL rst_reg%0d got=%0h exp=0", a, rd); bad++; end
            total++;
        end
        sample_in = '0;
        @(negedge PCI_CLK);
        PCI_RSTn = 1'b1;
        step();
    endtask

    task automatic test_regs();
        logic [31:0] rd;
        logic [31:0] exp_v [8];
        cfg_write(3'd0, 32'hA5A5_5A5A);
        cfg_write(3'd1, 32'hDEAD_BEEF);
        cfg_write(3'd2, 32'h1234_5678);
        cfg_write(3'd3, 32'hFFFF_0001);
        cfg_write(3'd5, 32'h0000_01C8);
        cfg_write(3'd4, 32'hFFFF_FFFE);
        cfg_write(3'd6, 32'hFFFF_FFFF);
        cfg_write(3'd7, 32'hFFFF_FFFF);
        exp_v = '{32'hA5A5_5A5A, 32'h0000_BEEF, 32'h1234_5678, 32'h0000_0001,
                  32'h0000_0002, 32'h0000_00C8, 32'h0000_0000, 32'h0000_0000};
        for (int a = 0; a < 8; a++) begin
            cfg_read(3'(a), rd);
            if (rd !== exp_v[a]) begin $display("FAIL reg%0d got=%0h exp=%0h", a, rd, exp_v[a]); bad++; end
            total++;
        end
        if (ram_we !== 1'b0) begin $display("FAIL regs_idle_we got=%0b exp=0", ram_we); bad++; end
        total++;
        cfg_write(3'd4, 32'h0);
    endtask

    task automatic test_basic_trigger();
        logic [31:0] rd;
        int wr;
        bit to;
        set_ad_match(32'd100);
        arm(1'b0);
        cfg_read(3'd6, rd);
        if (rd !== 32'h0000_0001) begin $display("FAIL basic_armed_status got=%0h exp=1", rd); bad++; end
        total++;
        if (ram_we !== 1'b1 || ram_addr !== 8'd0) begin
            $display("FAIL basic_first_write got=we%0b/addr%0d exp=we1/addr0", ram_we, ram_addr); bad++;
        end
        total++;
        put_sample(300, HIT);
        if (ram_addr !== 8'd44 || ram_wdata !== HIT) begin
            $display("FAIL basic_hit_write got=addr%0d/data%0h exp=addr44/data%0h", ram_addr, ram_wdata, HIT); bad++;
        end
        total++;
        wait_done(wr, to);
        if (to) begin $display("FAIL basic_done_timeout got=no_done exp=done"); bad++; end
        total++;
        if (wr !== 101) begin $display("FAIL basic_writes got=%0d exp=101", wr); bad++; end
        total++;
        if (ram_addr !== 8'd145) begin $display("FAIL basic_final_ptr got=%0d exp=145", ram_addr); bad++; end
        total++;
        cfg_read(3'd6, rd);
        if (rd !== 32'h0000_2C03) begin $display("FAIL basic_status got=%0h exp=2c03", rd); bad++; end
        total++;
        repeat (5) step();
        if (ram_we !== 1'b0 || done !== 1'b1 || ram_addr !== 8'd145) begin
            $display("FAIL basic_frozen got=we%0b/done%0b/addr%0d exp=we0/done1/addr145", ram_we, done, ram_addr); bad++;
        end
        total++;
    endtask

    task automatic test_pre_fill();
        logic [31:0] rd;
        int wr;
        bit to;
        cfg_write(3'd5, 32'd200);
        arm(1'b0);
        put_sample(10, HIT);
        advance_to(11);
        cfg_read(3'd6, rd);
        if (rd[1:0] !== 2'd1) begin $display("FAIL prefill_ignored got=%0d exp=1", rd[1:0]); bad++; end
        total++;
        put_sample(60, HIT);
        wait_done(wr, to);
        if (to || wr !== 201) begin $display("FAIL prefill_writes got=%0d exp=201", wr); bad++; end
        total++;
        if (ram_addr !== 8'd5) begin $display("FAIL prefill_final_ptr got=%0d exp=5", ram_addr); bad++; end
        total++;
        cfg_read(3'd6, rd);
        if (rd !== 32'h0000_3C03) begin $display("FAIL prefill_status got=%0h exp=3c03", rd); bad++; end
        total++;
    endtask

    task automatic test_post_zero();
        logic [31:0] rd;
        cfg_write(3'd5, 32'd0);
        arm(1'b0);
        put_sample(250, HIT);
        advance_to(251);
        cfg_read(3'd6, rd);
        if (rd[1:0] !== 2'd1) begin $display("FAIL post0_unfilled got=%0d exp=1", rd[1:0]); bad++; end
        total++;
        put_sample(276, HIT);
        advance_to(277);
        cfg_read(3'd6, rd);
        if (rd[1:0] !== 2'd2 || ram_we !== 1'b0) begin
            $display("FAIL post0_post_cycle got=st%0d/we%0b exp=st2/we0", rd[1:0], ram_we); bad++;
        end
        total++;
        advance_to(278);
        if (done !== 1'b1 || ram_addr !== 8'd21) begin
            $display("FAIL post0_done got=done%0b/addr%0d exp=done1/addr21", done, ram_addr); bad++;
        end
        total++;
        cfg_read(3'd6, rd);
        if (rd !== 32'h0000_1403) begin $display("FAIL post0_status got=%0h exp=1403", rd); bad++; end
        total++;
        arm(1'b0);
        if (done !== 1'b0 || ram_addr !== 8'd0 || ram_we !== 1'b1) begin
            $display("FAIL rearm_from_done got=done%0b/addr%0d/we%0b exp=done0/addr0/we1", done, ram_addr, ram_we); bad++;
        end
        total++;
        cfg_write(3'd4, 32'h0);
    endtask

    task automatic test_zero_mask();
        logic [31:0] rd;
        int wr;
        bit to;
        cfg_write(3'd0, 32'h0);
        cfg_write(3'd1, 32'h0);
        cfg_write(3'd5, 32'd50);
        for (int e = 1; e >= 0; e--) begin
            arm(e[0]);
            advance_to(206);
            cfg_read(3'd6, rd);
            if (rd[1:0] !== 2'd1 || ram_addr !== 8'd206) begin
                $display("FAIL zmask%0d_before got=st%0d/addr%0d exp=st1/addr206", e, rd[1:0], ram_addr); bad++;
            end
            total++;
            wait_done(wr, to);
            if (to || wr !== 51) begin $display("FAIL zmask%0d_writes got=%0d exp=51", e, wr); bad++; end
            total++;
            cfg_read(3'd6, rd);
            if (rd !== 32'h0000_CE03 || ram_addr !== 8'd1) begin
                $display("FAIL zmask%0d_status got=%0h/addr%0d exp=ce03/addr1", e, rd, ram_addr); bad++;
            end
            total++;
        end
    endtask

    task automatic test_edge_discard();
        logic [31:0] rd;
        set_ad_match(32'd100);
        for (int e = 0; e < 2; e++) begin
            arm(e[0]);
            advance_to(199);
            sample_in = HIT;
            advance_to(200);
            cfg_we = 1'b1; cfg_addr = 3'd7; cfg_wdata = 32'h0;
            advance_to(201);
            cfg_we = 1'b0;
            cfg_read(3'd6, rd);
            if (rd[1:0] !== 2'd1) begin $display("FAIL discard%0d_state got=%0d exp=1", e, rd[1:0]); bad++; end
            total++;
            if (e == 0) begin
                advance_to(202);
                sample_in = '0;
                cfg_read(3'd6, rd);
                if (rd !== 32'h0000_C902) begin $display("FAIL level_retrig got=%0h exp=c902", rd); bad++; end
                total++;
            end else begin
                advance_to(209);
                sample_in = '0;
                advance_to(210);
                cfg_read(3'd6, rd);
                if (rd[1:0] !== 2'd1) begin $display("FAIL edge_held_level got=%0d exp=1", rd[1:0]); bad++; end
                total++;
                put_sample(220, HIT);
                advance_to(221);
                cfg_read(3'd6, rd);
                if (rd !== 32'h0000_DC02) begin $display("FAIL edge_new_edge got=%0h exp=dc02", rd); bad++; end
                total++;
            end
            cfg_write(3'd4, 32'h0);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        arm(1'b0);
        advance_to(20);
        cfg_write(3'd4, 32'h0);
        cfg_read(3'd6, rd);
        if (ram_we !== 1'b0 || rd[1:0] !== 2'd0 || done !== 1'b0) begin
            $display("FAIL abort got=we%0b/st%0d/done%0b exp=we0/st0/done0", ram_we, rd[1:0], done); bad++;
        end
        total++;
    endtask

    task automatic test_reset_mid_post();
        logic [31:0] rd;
        cfg_write(3'd0, 32'h0);
        cfg_write(3'd1, 32'h0);
        cfg_write(3'd5, 32'd50);
        sample_in = 48'h1234_5678_9ABC;
        arm(1'b0);
        advance_to(210);
        cfg_read(3'd6, rd);
        if (rd[1:0] !== 2'd2 || ram_we !== 1'b1) begin
            $display("FAIL midpost_setup got=st%0d/we%0b exp=st2/we1", rd[1:0], ram_we); bad++;
        end
        total++;
        PCI_RSTn = 1'b0;
        #1;
        if (ram_we !== 1'b0 || ram_addr !== 8'd0 || ram_wdata !== 48'd0 || done !== 1'b0 || cfg_rdata !== 32'd0) begin
            $display("FAIL midpost_async got=we%0b/addr%0d/data%0h/done%0b/st%0h exp=all0",
                     ram_we, ram_addr, ram_wdata, done, cfg_rdata); bad++;
        end
        total++;
        @(negedge PCI_CLK);
        PCI_RSTn = 1'b1;
        step();
        cfg_read(3'd5, rd);
        if (rd !== 32'd0) begin $display("FAIL midpost_post_reg got=%0d exp=0", rd); bad++; end
        total++;
        repeat (60) step();
        cfg_read(3'd6, rd);
        if (done !== 1'b0 || rd !== 32'd0 || ram_we !== 1'b0) begin
            $display("FAIL midpost_after got=done%0b/st%0h/we%0b exp=done0/st0/we0", done, rd, ram_we); bad++;
        end
        total++;
        sample_in = '0;
    endtask

    initial begin
        test_reset();
        test_regs();
        test_basic_trigger();
        test_pre_fill();
        test_post_zero();
        test_zero_mask();
        test_edge_discard();
        test_abort();
        test_reset_mid_post();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
